// File: rtl/port_pattern_driver_if.sv
// Handshake bundle for port_pattern_driver: pattern input stream and response output stream.
// The master side is the producer/consumer environment; the slave side is the driver block.
interface port_pattern_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_pat;
  logic       resp_valid;
  logic       resp_ready;
  logic [3:0] resp_data;

  modport master (
    output in_valid, in_pat, resp_ready,
    input  in_ready, resp_valid, resp_data
  );

  modport slave (
    input  in_valid, in_pat, resp_ready,
    output in_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/port_pattern_driver.sv
// Queues {c,d} drive patterns, applies each to a downstream port pair for HOLD cycles,
// then captures {c,d,a,b} as a response held until the consumer accepts it.
module port_pattern_driver #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  port_pattern_driver_if.slave      bus,
  output logic                      c_out,
  output logic                      d_out,
  input  logic                      a_in,
  input  logic                      b_in,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(HOLD) + 1;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t        r_state;
  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [HW-1:0] r_hold;
  logic          r_c;
  logic          r_d;
  logic          r_resp_valid;
  logic [3:0]    r_resp_data;

  logic          w_in_ready;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_head;

  assign w_in_ready = (r_count < CW'(DEPTH));
  assign w_push     = bus.in_valid && w_in_ready;
  // Popping only from IDLE keeps a single pattern in flight.
  assign w_pop      = (r_state == IDLE) && (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];

  // NOTE: the storage array is deliberately not reset; pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= bus.in_pat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_c          <= 1'b0;
      r_d          <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_c     <= w_head[1];
            r_d     <= w_head[0];
            r_hold  <= HW'(HOLD - 1);
            r_state <= DRIVE;
          end
        end
        DRIVE: begin
          if (r_hold != '0) begin
            r_hold <= r_hold - HW'(1);
          end else begin
            r_resp_data  <= {r_c, r_d, a_in, b_in};
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          if (r_resp_valid && bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign c_out          = r_c;
  assign d_out          = r_d;
  assign count          = r_count;
  assign busy           = (r_state != IDLE) || (r_count != '0);

endmodule

// File: tb/tb_port_pattern_driver.sv
// Directed bench for port_pattern_driver (DEPTH=4, HOLD=3) with hand-computed expectations.
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
module tb_port_pattern_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       c_out, d_out;
  logic       a_in, b_in;
  logic [2:0] count;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  port_pattern_driver_if bus ();

  port_pattern_driver #(.DEPTH(4), .HOLD(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .c_out (c_out),
    .d_out (d_out),
    .a_in  (a_in),
    .b_in  (b_in),
    .count (count),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps edges until resp_valid is seen (bounded); n returns the edges taken.
  task automatic wait_resp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.resp_valid && n < 20);
    check("resp_wait", 32'(bus.resp_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] p [6];
    int         exp_cnt [6];
    int         n;
    logic       saw_valid;

    p       = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
    exp_cnt = '{1, 1, 2, 3, 4, 4};

    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_pat     = 2'b00;
    bus.resp_ready = 1'b0;
    a_in           = 1'b0;
    b_in           = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_count",      32'(count),          32'd0);
    check("rst_in_ready",   32'(bus.in_ready),   32'd1);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_data",  32'(bus.resp_data),  32'd0);
    check("rst_cd",         32'({c_out, d_out}), 32'd0);

    // Single pattern: drive on edge+1, response on edge+4, idle on edge+5.
    bus.in_valid = 1'b1; bus.in_pat = 2'b10;
    a_in = 1'b1; b_in = 1'b0; bus.resp_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("single_cnt_after_push", 32'(count), 32'd1);
    check("single_cd_not_yet",     32'({c_out, d_out}), 32'd0);
    tick();
    check("single_cd",             32'({c_out, d_out}), 32'b10);
    check("single_cnt_after_pop",  32'(count), 32'd0);
    tick();
    tick();
    check("single_not_early",      32'(bus.resp_valid), 32'd0);
    tick();
    check("single_valid",          32'(bus.resp_valid), 32'd1);
    check("single_data",           32'(bus.resp_data),  32'b1010);
    tick();
    check("single_cleared",        32'(bus.resp_valid), 32'd0);
    check("single_idle",           32'(busy),           32'd0);

    // Fill while the consumer stalls: five accepted, the sixth dropped.
    bus.resp_ready = 1'b0; a_in = 1'b0; b_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_pat   = p[i];
      check($sformatf("fill_ready_%0d", i), 32'(bus.in_ready), (i < 5) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("fill_count_%0d", i), 32'(count), 32'(exp_cnt[i]));
    end
    bus.in_valid = 1'b0;
    check("full_in_ready", 32'(bus.in_ready),   32'd0);
    check("first_valid",   32'(bus.resp_valid), 32'd1);
    check("first_data",    32'(bus.resp_data),  32'b0001);

    // Stalled response must stay put and nothing further is popped.
    a_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("stall_valid_%0d", i), 32'(bus.resp_valid), 32'd1);
      check($sformatf("stall_data_%0d", i),  32'(bus.resp_data),  32'b0001);
      check($sformatf("stall_count_%0d", i), 32'(count),          32'd4);
    end
    a_in = 1'b0;

    // Drain in order at one response per HOLD+2 edges.
    bus.resp_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      wait_resp(n);
      check($sformatf("drain_data_%0d", k), 32'(bus.resp_data), 32'({p[k], 2'b01}));
      check($sformatf("drain_gap_%0d", k),  32'(n), 32'd5);
    end
    tick();
    check("drain_empty", 32'(count), 32'd0);

    // Push coincident with pop at count=2; entry D lands across the pointer wrap.
    bus.resp_ready = 1'b0; a_in = 1'b1; b_in = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_pat = 2'b01; tick();
    bus.in_pat = 2'b10; tick();
    check("pp_cnt1", 32'(count), 32'd1);
    bus.in_pat = 2'b11; tick();
    bus.in_valid = 1'b0;
    wait_resp(n);
    check("pp_a_data",   32'(bus.resp_data), 32'b0111);
    check("pp_pre_cnt",  32'(count),         32'd2);
    bus.resp_ready = 1'b1;
    tick();
    check("pp_idle_cnt", 32'(count), 32'd2);
    bus.in_valid = 1'b1; bus.in_pat = 2'b00;
    tick();
    bus.in_valid = 1'b0;
    check("pp_cnt2", 32'(count), 32'd2);
    wait_resp(n);
    check("pp_b_data", 32'(bus.resp_data), 32'b1011);
    check("pp_b_lat",  32'(n), 32'd3);
    wait_resp(n);
    check("pp_c_data", 32'(bus.resp_data), 32'b1111);
    wait_resp(n);
    check("pp_d_data", 32'(bus.resp_data), 32'b0011);
    tick();

    // a_in toggles during DRIVE; only the value at the sampling edge is captured.
    a_in = 1'b0; b_in = 1'b0;
    bus.in_valid = 1'b1; bus.in_pat = 2'b11;
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("tog_cd", 32'({c_out, d_out}), 32'b11);
    a_in = 1'b1; tick();
    check("tog_not_yet", 32'(bus.resp_valid), 32'd0);
    a_in = 1'b0; tick();
    a_in = 1'b1; tick();
    check("tog_valid", 32'(bus.resp_valid), 32'd1);
    check("tog_data",  32'(bus.resp_data),  32'b1110);
    a_in = 1'b0; bus.resp_ready = 1'b0;
    tick();
    check("tog_hold_data", 32'(bus.resp_data), 32'b1110);
    bus.resp_ready = 1'b1;
    tick();
    check("tog_released", 32'(bus.resp_valid), 32'd0);

    // Reset mid-DRIVE with three queued entries discards everything.
    bus.resp_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pat = 2'b11; tick();
    bus.in_pat = 2'b10; tick();
    bus.in_pat = 2'b01; tick();
    bus.in_pat = 2'b00; tick();
    check("mid_count", 32'(count), 32'd3);
    check("mid_busy",  32'(busy),  32'd1);
    check("mid_cd",    32'({c_out, d_out}), 32'b11);
    reset = 1'b1; bus.in_pat = 2'b10; bus.resp_ready = 1'b1;
    tick();
    reset = 1'b0; bus.in_valid = 1'b0;
    check("mrst_count",    32'(count),          32'd0);
    check("mrst_valid",    32'(bus.resp_valid), 32'd0);
    check("mrst_cd",       32'({c_out, d_out}), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready),   32'd1);
    check("mrst_busy",     32'(busy),           32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      saw_valid = saw_valid | bus.resp_valid;
    end
    check("mrst_no_stale", 32'(saw_valid), 32'd0);
    check("mrst_count_end", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/port_pattern_driver.md
PORT_PATTERN_DRIVER -- requirements
Module: port_pattern_driver

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning pattern FIFO depth (power of two, >= 2).
REQ-002 The block SHALL have parameter HOLD, default 3, meaning cycles each pattern is driven before responses are sampled (>= 1).
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  upstream pattern valid.
REQ-006 The block SHALL have port in_ready  output  1  FIFO can accept a pattern.
REQ-007 The block SHALL have port in_pat  input  2  pattern {c,d}.
REQ-008 The block SHALL have port c_out  output  1  registered drive to the downstream C input.
REQ-009 The block SHALL have port d_out  output  1  registered drive to the downstream D input.
REQ-010 The block SHALL have port a_in  input  1  downstream A output (net).
REQ-011 The block SHALL have port b_in  input  1  downstream B output.
REQ-012 The block SHALL have port resp_valid  output  1  response available.
REQ-013 The block SHALL have port resp_ready  input  1  consumer accepts response.
REQ-014 The block SHALL have port resp_data  output  4  {c,d,a,b} captured at sample time.
REQ-015 The block SHALL have port count  output  log2(DEPTH)+1  FIFO occupancy.
REQ-016 The block SHALL have port busy  output  1  high when state != IDLE or count != 0.

Function
REQ-017 The FIFO SHALL be circular with read/write pointers wrapping modulo DEPTH; in_ready = (count < DEPTH).
REQ-018 A push SHALL occur on an edge with in_valid && in_ready; in_valid with in_ready low SHALL be ignored without corrupting the FIFO.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, store the new entry, and advance both pointers.
REQ-020 The FSM SHALL have exactly the states IDLE, DRIVE and RESP.
REQ-021 In IDLE with count != 0, the block SHALL pop the head, load c_out/d_out from it, load the hold counter with HOLD-1, and enter DRIVE on the same edge.
REQ-022 In IDLE with count == 0, the block SHALL remain in IDLE, and c_out/d_out SHALL retain their last values.
REQ-023 In DRIVE, the hold counter SHALL decrement each edge while non-zero.
REQ-024 In DRIVE, on the edge where the hold counter == 0, the block SHALL capture {c_out,d_out,a_in,b_in} into resp_data, set resp_valid, and enter RESP.
REQ-025 In RESP, resp_valid and resp_data SHALL remain stable until resp_valid && resp_ready; on that edge resp_valid SHALL clear and the FSM SHALL enter IDLE.
REQ-026 A pop SHALL occur only in IDLE, so at most one pattern is in flight.
REQ-027 Latency from a push into an empty FIFO with the FSM in IDLE to resp_valid high SHALL be HOLD+1 edges; c_out/d_out SHALL change 1 edge after the push.
REQ-028 Back-to-back throughput SHALL be one pattern per HOLD+2 cycles when resp_ready is held high.
REQ-029 The FIFO SHALL keep accepting pushes while the FSM is in DRIVE or RESP, up to DEPTH entries.

Reset
REQ-030 While reset is high at an edge, the block SHALL set state=IDLE, both pointers=0, count=0, hold counter=0, c_out=0, d_out=0, resp_valid=0, resp_data=0; busy and in_ready therefore read 0 and 1.
REQ-031 Reset SHALL have priority over push, pop and response handshake, and SHALL discard FIFO contents and any in-flight pattern when asserted mid-operation.

Verification
REQ-032 The bench SHALL check: reset, then push in_pat=2'b10 once, with a_in=1, b_in=0 and resp_ready=1 -> c_out=1, d_out=0 one edge later; resp_valid high 4 edges after the push with resp_data=4'b1010; the FSM is back in IDLE the next edge.
REQ-033 The bench SHALL check: push 5 patterns back-to-back while resp_ready=0 -> in_ready falls once count=4 (one popped, four queued); the extra push is dropped; four responses later emerge in order.
REQ-034 The bench SHALL check: resp_ready=0 for 10 cycles in RESP -> resp_valid and resp_data stay stable; no further pop occurs; count is unchanged except by pushes.
REQ-035 The bench SHALL check: a push on the same edge as a pop with count=2 -> count stays 2; order is preserved across pointer wrap after 6 total patterns.
REQ-036 The bench SHALL check: reset asserted in DRIVE with count=3 -> next cycle count=0, resp_valid=0, c_out=d_out=0, in_ready=1, busy=0; no stale response ever appears.
REQ-037 The bench SHALL check: a_in toggles during DRIVE -> resp_data captures the value present at the sampling edge only.
